hazard_ctrl_unit: RTL and testbench

// Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits between ID and EX control.

---
 rtl/hazard_ctrl_unit.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller between ID and EX: load-use and branch stalls,
// taken-branch flush, counted HALT drain and saturating perf counters.
module hazard_ctrl_unit #(
  parameter int NB_REG            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_HAZARD_EN  = 1,
  parameter int DRAIN_CYCLES      = 4,
  parameter int NB_CNT            = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_rt_i,
  input  logic              ex_reg_write_i,
  input  logic [NB_REG-1:0] ex_write_reg_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_is_branch_i,
  input  logic              branch_taken_i,
  input  logic              halt_i,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              halted_o,
  output logic [NB_CNT-1:0] stall_count_o,
  output logic [NB_CNT-1:0] flush_count_o
);

  localparam int CMAX = (LOAD_STALL_CYCLES > DRAIN_CYCLES) ?
                        LOAD_STALL_CYCLES : DRAIN_CYCLES;
  localparam int NB_C = $clog2(CMAX + 1);
  localparam int LD_INIT = (LOAD_STALL_CYCLES > 1) ?
                           LOAD_STALL_CYCLES - 2 : 0;
  localparam logic [NB_C-1:0] LD_LOAD = NB_C'(LD_INIT);
  localparam logic [NB_C-1:0] DR_LOAD = NB_C'(DRAIN_CYCLES - 1);
  localparam logic LD_MULTI = (LOAD_STALL_CYCLES > 1);
  localparam logic BR_EN = (BRANCH_HAZARD_EN != 0);

  typedef enum logic [1:0] {
    RUN, LD_STALL, HALT_DRAIN, HALTED
  } state_t;

  state_t state_q, state_d;
  logic [NB_C-1:0] cnt_q, cnt_d;
  logic [NB_CNT-1:0] stall_cnt_q, flush_cnt_q;

  logic rs_ld, rt_ld, rs_br, rt_br;
  logic lu, bh;
  logic stall_c, flush_c, halted_c, count_stall;

  // Register 0 never carries a real dependency.
  assign rs_ld = (id_rs_i != '0) && (ex_rt_i == id_rs_i);
  assign rt_ld = (id_rt_i != '0) && (ex_rt_i == id_rt_i);
  assign rs_br = (id_rs_i != '0) && (ex_write_reg_i == id_rs_i);
  assign rt_br = (id_rt_i != '0) && (ex_write_reg_i == id_rt_i);

  assign lu = ex_mem_read_i & (rs_ld | (id_uses_rt_i & rt_ld));
  assign bh = BR_EN & id_is_branch_i & ex_reg_write_i & (rs_br | rt_br);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (halt_i) begin
          state_d = HALT_DRAIN;
          cnt_d   = DR_LOAD;
        end else if (lu && LD_MULTI) begin
          state_d = LD_STALL;
          cnt_d   = LD_LOAD;
        end
      end
      LD_STALL: begin
        if (halt_i) begin
          state_d = HALT_DRAIN;
          cnt_d   = DR_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALT_DRAIN: begin
        if (cnt_q == '0) state_d = HALTED;
        else cnt_d = cnt_q - 1'b1;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    halted_c    = 1'b0;
    count_stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (halt_i) begin
            stall_c = 1'b1;
          end else if (lu || bh) begin
            stall_c     = 1'b1;
            count_stall = 1'b1;
          end else if (branch_taken_i) begin
            flush_c = 1'b1;
          end
        end
        LD_STALL: begin
          stall_c     = 1'b1;
          count_stall = !halt_i;
        end
        HALT_DRAIN: stall_c = 1'b1;
        HALTED: begin
          stall_c  = 1'b1;
          halted_c = 1'b1;
        end
        default: stall_c = 1'b0;
      endcase
    end
  end

  assign stall_o       = stall_c;
  assign pc_write_o    = !stall_c;
  assign if_id_write_o = !stall_c;
  assign id_ex_flush_o = stall_c;
  assign if_id_flush_o = flush_c;
  assign halted_o      = halted_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (count_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + NB_CNT'(1);
      if (flush_c && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + NB_CNT'(1);
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios on two parameter sets
// plus randomized traffic against a cycle-indexed reference model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, reg_write, uses_rt, is_branch, taken, halt;
  logic [4:0] ex_rt, ex_wr, rs, rt;

  logic a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted;
  logic [15:0] a_scnt, a_fcnt;
  logic b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted;
  logic [3:0] b_scnt, b_fcnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1)) dut_a (
    .clock(clk), .reset(rst),
    .ex_mem_read_i(mem_read), .ex_rt_i(ex_rt),
    .ex_reg_write_i(reg_write), .ex_write_reg_i(ex_wr),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
    .id_is_branch_i(is_branch), .branch_taken_i(taken),
    .halt_i(halt),
    .stall_o(a_stall), .pc_write_o(a_pcw),
    .if_id_write_o(a_ifw), .if_id_flush_o(a_iff),
    .id_ex_flush_o(a_idf), .halted_o(a_halted),
    .stall_count_o(a_scnt), .flush_count_o(a_fcnt)
  );

  hazard_ctrl_unit #(
    .LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(4), .NB_CNT(4)
  ) dut_b (
    .clock(clk), .reset(rst),
    .ex_mem_read_i(mem_read), .ex_rt_i(ex_rt),
    .ex_reg_write_i(reg_write), .ex_write_reg_i(ex_wr),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
    .id_is_branch_i(is_branch), .branch_taken_i(taken),
    .halt_i(halt),
    .stall_o(b_stall), .pc_write_o(b_pcw),
    .if_id_write_o(b_ifw), .if_id_flush_o(b_iff),
    .id_ex_flush_o(b_idf), .halted_o(b_halted),
    .stall_count_o(b_scnt), .flush_count_o(b_fcnt)
  );

  // Flag order: {stall, pc_write, if_id_write, if_id_flush, id_ex_flush, halted}
  localparam logic [5:0] F_NORM  = 6'b011000;
  localparam logic [5:0] F_FLUSH = 6'b011100;
  localparam logic [5:0] F_STALL = 6'b100010;
  localparam logic [5:0] F_HALT  = 6'b100011;

  int m_lsc [2] = '{1, 3};
  int m_max [2] = '{65535, 15};
  int m_ld_end [2];
  int m_halt [2];
  int m_scnt [2];
  int m_fcnt [2];
  int m_cls [2];
  logic [5:0] m_flags [2];
  int m_cyc;

  task automatic clear_inputs();
    mem_read = 0; reg_write = 0; uses_rt = 0;
    is_branch = 0; taken = 0; halt = 0;
    ex_rt = 0; ex_wr = 0; rs = 0; rt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_eval(input int k);
    logic lu, bh;
    lu = mem_read && ((rs != 0 && ex_rt == rs) ||
                      (uses_rt && rt != 0 && ex_rt == rt));
    bh = is_branch && reg_write &&
         ((rs != 0 && ex_wr == rs) || (rt != 0 && ex_wr == rt));
    m_cls[k] = 0;
    if (rst) m_flags[k] = F_NORM;
    else if (m_halt[k] >= 0)
      m_flags[k] = (m_cyc >= m_halt[k] + 5) ? F_HALT : F_STALL;
    else if (halt) begin m_flags[k] = F_STALL; m_cls[k] = 1; end
    else if (m_cyc < m_ld_end[k]) begin m_flags[k] = F_STALL; m_cls[k] = 2; end
    else if (lu) begin m_flags[k] = F_STALL; m_cls[k] = 3; end
    else if (bh) begin m_flags[k] = F_STALL; m_cls[k] = 2; end
    else if (taken) begin m_flags[k] = F_FLUSH; m_cls[k] = 5; end
    else m_flags[k] = F_NORM;
  endtask

  task automatic model_commit(input int k);
    if (rst) begin
      m_ld_end[k] = 0; m_halt[k] = -1; m_scnt[k] = 0; m_fcnt[k] = 0;
    end else begin
      if (m_cls[k] == 1) m_halt[k] = m_cyc;
      if (m_cls[k] == 3) m_ld_end[k] = m_cyc + m_lsc[k];
      if ((m_cls[k] == 2 || m_cls[k] == 3) && m_scnt[k] < m_max[k])
        m_scnt[k]++;
      if (m_cls[k] == 5 && m_fcnt[k] < m_max[k]) m_fcnt[k]++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; halt = 1; mem_read = 1; ex_rt = 3; rs = 3; taken = 1;
    @(negedge clk);
    tests++;
    if ({a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted} !== F_NORM ||
        {b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted} !== F_NORM) begin
      fails++;
      $display("FAIL reset_forced: a=%b b=%b expected %b",
        {a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted},
        {b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted}, F_NORM);
    end
    step();
    clear_inputs(); rst = 1'b0;
    @(negedge clk);
    tests++;
    if (a_scnt !== 0 || a_fcnt !== 0 || b_scnt !== 0 || b_fcnt !== 0 ||
        a_stall !== 0 || b_halted !== 0) begin
      fails++;
      $display("FAIL reset_state: cnts=%0d/%0d/%0d/%0d stall=%b expected zeros",
        a_scnt, a_fcnt, b_scnt, b_fcnt, a_stall);
    end
    step();
  endtask

  task automatic test_load_one();
    do_reset();
    mem_read = 1; ex_rt = 3; rs = 3;
    @(negedge clk);
    tests++;
    if (a_stall !== 1 || a_pcw !== 0 || a_idf !== 1 || a_ifw !== 0) begin
      fails++;
      $display("FAIL load1_stall: stall=%b pcw=%b idf=%b expected 1 0 1",
        a_stall, a_pcw, a_idf);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests++;
    if (a_stall !== 0 || a_pcw !== 1 || a_scnt !== 1) begin
      fails++;
      $display("FAIL load1_release: stall=%b pcw=%b cnt=%0d expected 0 1 1",
        a_stall, a_pcw, a_scnt);
    end
    step();
  endtask

  task automatic test_load_multi();
    int n;
    do_reset();
    mem_read = 1; ex_rt = 3; rs = 3;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_stall === 1'b1) n++;
      if (i == 3) begin
        tests++;
        if (b_pcw !== 1) begin
          fails++;
          $display("FAIL load3_pcw: pc_write=%b expected 1", b_pcw);
        end
      end
      step();
      if (i == 0) clear_inputs();
    end
    @(negedge clk);
    tests++;
    if (n != 3 || b_scnt !== 3) begin
      fails++;
      $display("FAIL load3_count: stalls=%0d cnt=%0d expected 3 3", n, b_scnt);
    end
    step();
  endtask

  task automatic test_zero_reg();
    do_reset();
    mem_read = 1; ex_rt = 0; rs = 0;
    @(negedge clk);
    tests++;
    if (a_stall !== 0 || b_stall !== 0) begin
      fails++;
      $display("FAIL zero_reg: stall=%b/%b expected 0", a_stall, b_stall);
    end
    step();
    ex_rt = 7; rt = 7; rs = 2; uses_rt = 0;
    @(negedge clk);
    tests++;
    if (a_stall !== 0) begin
      fails++;
      $display("FAIL rt_unused: stall=%b expected 0", a_stall);
    end
    step();
    uses_rt = 1;
    @(negedge clk);
    tests++;
    if (a_stall !== 1) begin
      fails++;
      $display("FAIL rt_used: stall=%b expected 1", a_stall);
    end
    step();
  endtask

  task automatic test_branch();
    do_reset();
    is_branch = 1; reg_write = 1; ex_wr = 5; rt = 5; rs = 1;
    @(negedge clk);
    tests++;
    if (a_stall !== 1 || a_iff !== 0) begin
      fails++;
      $display("FAIL branch_stall: stall=%b flush=%b expected 1 0", a_stall, a_iff);
    end
    step();
    reg_write = 0; taken = 1;
    @(negedge clk);
    tests++;
    if (a_iff !== 1 || a_stall !== 0 || a_pcw !== 1 || a_ifw !== 1) begin
      fails++;
      $display("FAIL branch_flush: flush=%b stall=%b pcw=%b expected 1 0 1",
        a_iff, a_stall, a_pcw);
    end
    step();
    clear_inputs();
    @(negedge clk);
    tests++;
    if (a_fcnt !== 1 || a_scnt !== 1) begin
      fails++;
      $display("FAIL branch_counts: flush=%0d stall=%0d expected 1 1", a_fcnt, a_scnt);
    end
    step();
  endtask

  task automatic test_halt();
    logic exp_h;
    do_reset();
    mem_read = 1; ex_rt = 3; rs = 3;
    step();
    clear_inputs(); halt = 1;
    @(negedge clk);
    tests++;
    if (a_stall !== 1 || b_stall !== 1 || a_halted !== 0) begin
      fails++;
      $display("FAIL halt_entry: stall=%b/%b halted=%b expected 1 1 0",
        a_stall, b_stall, a_halted);
    end
    step();
    halt = 0;
    for (int i = 1; i <= 9; i++) begin
      halt = (i == 2);
      taken = (i == 7);
      @(negedge clk);
      exp_h = (i >= 5);
      tests++;
      if (a_halted !== exp_h || b_halted !== exp_h ||
          a_stall !== 1 || b_stall !== 1 || b_pcw !== 0 || a_iff !== 0) begin
        fails++;
        $display("FAIL halt_drain_%0d: halted=%b/%b stall=%b/%b expected %b 1",
          i, a_halted, b_halted, a_stall, b_stall, exp_h);
      end
      step();
    end
    rst = 1; mem_read = 1; ex_rt = 3; rs = 3;
    @(negedge clk);
    tests++;
    if ({a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted} !== F_NORM ||
        {b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted} !== F_NORM) begin
      fails++;
      $display("FAIL halt_reset: a=%b b=%b expected %b",
        {a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted},
        {b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted}, F_NORM);
    end
    step();
    clear_inputs(); rst = 0;
    @(negedge clk);
    tests++;
    if (a_halted !== 0 || b_halted !== 0 || b_stall !== 0 ||
        a_scnt !== 0 || b_scnt !== 0) begin
      fails++;
      $display("FAIL halt_exit: halted=%b/%b stall=%b cnt=%0d/%0d expected 0",
        a_halted, b_halted, b_stall, a_scnt, b_scnt);
    end
    step();
  endtask

  task automatic test_saturate();
    int miss;
    do_reset();
    mem_read = 1; ex_rt = 3; rs = 3;
    miss = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (b_stall !== 1) miss++;
      step();
    end
    clear_inputs();
    @(negedge clk);
    tests++;
    if (b_scnt !== 4'd15 || a_scnt !== 16'd21 || miss != 0) begin
      fails++;
      $display("FAIL saturate: b=%0d a=%0d misses=%0d expected 15 21 0",
        b_scnt, a_scnt, miss);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    m_cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_ld_end[k] = 0; m_halt[k] = -1; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      halt      = ($urandom_range(0, 59) == 0);
      mem_read  = ($urandom_range(0, 2) == 0);
      reg_write = $urandom_range(0, 1);
      is_branch = ($urandom_range(0, 2) == 0);
      taken     = $urandom_range(0, 1);
      uses_rt   = $urandom_range(0, 1);
      ex_rt     = 5'($urandom_range(0, 3));
      ex_wr     = 5'($urandom_range(0, 3));
      rs        = 5'($urandom_range(0, 3));
      rt        = 5'($urandom_range(0, 3));
      @(negedge clk);
      model_eval(0);
      model_eval(1);
      tests++;
      if ({a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted} !== m_flags[0] ||
          a_scnt !== 16'(m_scnt[0]) || a_fcnt !== 16'(m_fcnt[0])) begin
        fails++;
        $display("FAIL rand_a cyc %0d: got %b %0d %0d expected %b %0d %0d",
          i, {a_stall, a_pcw, a_ifw, a_iff, a_idf, a_halted}, a_scnt, a_fcnt,
          m_flags[0], m_scnt[0], m_fcnt[0]);
      end
      tests++;
      if ({b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted} !== m_flags[1] ||
          b_scnt !== 4'(m_scnt[1]) || b_fcnt !== 4'(m_fcnt[1])) begin
        fails++;
        $display("FAIL rand_b cyc %0d: got %b %0d %0d expected %b %0d %0d",
          i, {b_stall, b_pcw, b_ifw, b_iff, b_idf, b_halted}, b_scnt, b_fcnt,
          m_flags[1], m_scnt[1], m_fcnt[1]);
      end
      model_commit(0);
      model_commit(1);
      m_cyc++;
      step();
    end
    clear_inputs();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    test_reset();
    test_load_one();
    test_load_multi();
    test_zero_reg();
    test_branch();
    test_halt();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
